// File: rtl/dbg_mem_loader.sv
// rtl/dbg_mem_loader.sv - byte-command debug memory loader driving the SoC debug port and CPU reset
// Optional feature macro: DBG_LOADER_ACK_EN (0x06/0x15 response byte after non-read commands).
module dbg_mem_loader #(
    parameter int              ADR_W        = 32,
    parameter int              DATA_W       = 32,
    parameter logic [ADR_W-1:0] BASE_ADR    = 'h20000,
    parameter int              TIMEOUT_CYC  = 100000,
    parameter int              RUN_ON_RESET = 0
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 cpu_n_reset,
    output logic                 dbg_mem_op,
    output logic [DATA_W/8-1:0]  dbg_wren,
    output logic [ADR_W-1:0]     dbg_adr,
    output logic [DATA_W-1:0]    dbg_do,
    input  logic [DATA_W-1:0]    dbg_di
);
    localparam int NB   = DATA_W / 8;
    localparam int AB   = ADR_W / 8;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0] CMD_SETADR = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_RUN    = 8'h04;
    localparam logic [7:0] CMD_HALT   = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE, S_ADR, S_MASK, S_DATA, S_WR, S_RD, S_RD_CAP, S_TX
`ifdef DBG_LOADER_ACK_EN
        , S_ACK
`endif
    } state_t;

`ifdef DBG_LOADER_ACK_EN
    localparam state_t S_DONE = S_ACK;
    localparam state_t S_BAD  = S_ACK;
    logic [7:0] ack_code;
`else
    localparam state_t S_DONE = S_IDLE;
    localparam state_t S_BAD  = S_IDLE;
`endif

    state_t            state, state_n;
    logic [ADR_W-1:0]  ptr;
    logic [ADR_W-1:0]  adr_sh;
    logic [NB-1:0]     mask;
    logic [DATA_W-1:0] txw;
    logic [7:0]        cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              take;
    logic              collecting;
    logic              timeout_hit;

    assign collecting  = (state == S_ADR) || (state == S_MASK) || (state == S_DATA);
    assign rx_ready    = (state == S_IDLE) || collecting;
    assign take        = rx_valid && rx_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && collecting && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign dbg_adr     = ptr;

    always_comb begin
        state_n    = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        dbg_mem_op = 1'b0;
        dbg_wren   = '0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    case (rx_data)
                        CMD_SETADR: state_n = S_ADR;
                        CMD_WRITE:  state_n = S_MASK;
                        CMD_READ:   state_n = cpu_n_reset ? S_TX : S_RD;
                        CMD_RUN,
                        CMD_HALT:   state_n = S_DONE;
                        default:    state_n = S_BAD;
                    endcase
                end
            end
            S_ADR: begin
                if (take && cnt == 8'(AB - 1))
                    state_n = S_DONE;
                else if (!take && timeout_hit)
                    state_n = S_IDLE;
            end
            S_MASK: begin
                if (take)
                    state_n = S_DATA;
                else if (timeout_hit)
                    state_n = S_IDLE;
            end
            S_DATA: begin
                // A running CPU owns the bus: payload is swallowed without a cycle.
                if (take && cnt == 8'(NB - 1))
                    state_n = cpu_n_reset ? S_DONE : S_WR;
                else if (!take && timeout_hit)
                    state_n = S_IDLE;
            end
            S_WR: begin
                dbg_mem_op = 1'b1;
                dbg_wren   = mask;
                state_n    = S_DONE;
            end
            S_RD: begin
                dbg_mem_op = 1'b1;
                state_n    = S_RD_CAP;
            end
            S_RD_CAP: state_n = S_TX;
            S_TX: begin
                tx_valid = 1'b1;
                tx_data  = txw[7:0];
                if (tx_ready && cnt == 8'(NB - 1))
                    state_n = S_IDLE;
            end
`ifdef DBG_LOADER_ACK_EN
            S_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ack_code;
                if (tx_ready)
                    state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            ptr         <= BASE_ADR;
            adr_sh      <= '0;
            mask        <= '0;
            dbg_do      <= '0;
            txw         <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            cpu_n_reset <= (RUN_ON_RESET != 0);
`ifdef DBG_LOADER_ACK_EN
            ack_code    <= 8'h06;
`endif
        end else begin
            state <= state_n;
            if (take || !collecting || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (take) begin
                        if (rx_data == CMD_READ && cpu_n_reset)
                            txw <= '1;
                        if (rx_data == CMD_RUN)
                            cpu_n_reset <= 1'b1;
                        if (rx_data == CMD_HALT)
                            cpu_n_reset <= 1'b0;
`ifdef DBG_LOADER_ACK_EN
                        ack_code <= (rx_data >= CMD_SETADR && rx_data <= CMD_HALT) ? 8'h06 : 8'h15;
`endif
                    end
                end
                S_ADR: begin
                    if (take) begin
                        adr_sh <= {rx_data, adr_sh[ADR_W-1:8]};
                        cnt    <= cnt + 8'd1;
                        if (cnt == 8'(AB - 1))
                            ptr <= {rx_data, adr_sh[ADR_W-1:8]};
                    end
                end
                S_MASK: begin
                    if (take)
                        mask <= rx_data[NB-1:0];
                end
                S_DATA: begin
                    if (take) begin
                        dbg_do <= {rx_data, dbg_do[DATA_W-1:8]};
                        cnt    <= cnt + 8'd1;
                    end
                end
                S_WR:     ptr <= ptr + ADR_W'(NB);
                S_RD:     ptr <= ptr + ADR_W'(NB);
                S_RD_CAP: txw <= dbg_di;
                S_TX: begin
                    if (tx_ready) begin
                        txw <= txw >> 8;
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_mem_loader.sv
// tb/tb_dbg_mem_loader.sv - directed table-driven bench for dbg_mem_loader
module tb_dbg_mem_loader;
`ifdef DBG_LOADER_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di = 32'h0;

    dbg_mem_loader #(.ADR_W(32), .DATA_W(32), .BASE_ADR(32'h20000), .TIMEOUT_CYC(TO), .RUN_ON_RESET(0)) dut (
        .clk(clk), .n_reset(n_reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .cpu_n_reset(cpu_n_reset),
        .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do), .dbg_di(dbg_di)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          strobes = 0;
    logic [31:0] cap_adr = '0;
    logic [3:0]  cap_wren = '0;
    logic [31:0] cap_do = '0;
    logic [7:0]  tx_q [$];

    always @(negedge clk) begin
        if (n_reset && dbg_mem_op) begin
            strobes  = strobes + 1;
            cap_adr  = dbg_adr;
            cap_wren = dbg_wren;
            cap_do   = dbg_do;
        end
        if (n_reset && tx_valid && tx_ready)
            tx_q.push_back(tx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: byte 0x%02h not accepted within 200 cycles", b);
    endtask

    task automatic send_seq(input logic [47:0] bytes, input int n);
        for (int i = 0; i < n; i++) send(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tx_word();
        logic [31:0] w = '0;
        for (int i = 0; i < tx_q.size() && i < 4; i++) w[8*i +: 8] = tx_q[i];
        return w;
    endfunction

    typedef struct {
        string       name;
        logic [47:0] bytes;
        int          n;
        logic [31:0] di;
        int          stb;
        logic [31:0] adr;
        logic [3:0]  wren;
        logic [31:0] dout;
        int          ntx;
        logic [31:0] tx;
        logic [7:0]  ack;
        logic [31:0] ptr;
        logic        cpu;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{"setadr_20000", 48'h0100000200,   5, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'h00020000, 1'b0};
        vecs[1]  = '{"wr_full",      48'h020F37010000, 6, 32'h0,        1, 32'h00020000, 4'hF, 32'h00000137, 0, 32'h0,        8'h06, 32'h00020004, 1'b0};
        vecs[2]  = '{"setadr_0c",    48'h010C000000,   5, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'h0000000C, 1'b0};
        vecs[3]  = '{"wr_lane0",     48'h020132AABBCC, 6, 32'h0,        1, 32'h0000000C, 4'h1, 32'hCCBBAA32, 0, 32'h0,        8'h06, 32'h00000010, 1'b0};
        vecs[4]  = '{"wr_lane1",     48'h0202DD31EEFF, 6, 32'h0,        1, 32'h00000010, 4'h2, 32'hFFEE31DD, 0, 32'h0,        8'h06, 32'h00000014, 1'b0};
        vecs[5]  = '{"setadr_0c_b",  48'h010C000000,   5, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'h0000000C, 1'b0};
        vecs[6]  = '{"rd_0c",        48'h03,           1, 32'h00003132, 1, 32'h0000000C, 4'h0, 32'hFFEE31DD, 4, 32'h00003132, 8'h00, 32'h00000010, 1'b0};
        vecs[7]  = '{"setadr_top",   48'h01FCFFFFFF,   5, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'hFFFFFFFC, 1'b0};
        vecs[8]  = '{"wr_wrap",      48'h020F44332211, 6, 32'h0,        1, 32'hFFFFFFFC, 4'hF, 32'h11223344, 0, 32'h0,        8'h06, 32'h00000000, 1'b0};
        vecs[9]  = '{"wr_mask0",     48'h020055555555, 6, 32'h0,        1, 32'h00000000, 4'h0, 32'h55555555, 0, 32'h0,        8'h06, 32'h00000004, 1'b0};
        vecs[10] = '{"rd_4",         48'h03,           1, 32'hA5A55A5A, 1, 32'h00000004, 4'h0, 32'h55555555, 4, 32'hA5A55A5A, 8'h00, 32'h00000008, 1'b0};
        vecs[11] = '{"unknown_cmd",  48'h07,           1, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h15, 32'h00000008, 1'b0};
        vecs[12] = '{"run",          48'h04,           1, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'h00000008, 1'b1};
        vecs[13] = '{"rd_running",   48'h03,           1, 32'h12345678, 0, 32'h0,        4'h0, 32'h0,        4, 32'hFFFFFFFF, 8'h00, 32'h00000008, 1'b1};
        vecs[14] = '{"wr_running",   48'h020F01020304, 6, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'h00000008, 1'b1};
        vecs[15] = '{"halt",         48'h05,           1, 32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,        8'h06, 32'h00000008, 1'b0};
        vecs[16] = '{"rd_8",         48'h03,           1, 32'h0BADBEEF, 1, 32'h00000008, 4'h0, 32'h0,        4, 32'h0BADBEEF, 8'h00, 32'h0000000C, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_n_reset", 32'(cpu_n_reset), 32'h0);
        check("rst_dbg_adr",     dbg_adr,          32'h00020000);
        check("rst_dbg_mem_op",  32'(dbg_mem_op),  32'h0);
        check("rst_rx_ready",    32'(rx_ready),    32'h1);
        check("rst_tx_valid",    32'(tx_valid),    32'h0);
        check("rst_dbg_wren",    32'(dbg_wren),    32'h0);
        check("rst_dbg_do",      dbg_do,           32'h0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 17; v++) begin
            int          s0;
            int          exp_ntx;
            logic [31:0] exp_tx;
            tx_q.delete();
            s0     = strobes;
            dbg_di = vecs[v].di;
            send_seq(vecs[v].bytes, vecs[v].n);
            drain();
            exp_ntx = vecs[v].ntx;
            exp_tx  = vecs[v].tx;
            if (ACK != 0 && vecs[v].ack != 8'h00) begin
                exp_ntx = 1;
                exp_tx  = 32'(vecs[v].ack);
            end
            check({vecs[v].name, "_strobes"}, 32'(strobes - s0), 32'(vecs[v].stb));
            if (vecs[v].stb > 0) begin
                check({vecs[v].name, "_adr"},  cap_adr,        vecs[v].adr);
                check({vecs[v].name, "_wren"}, 32'(cap_wren),  32'(vecs[v].wren));
                if (vecs[v].wren != 4'h0 || vecs[v].n > 1)
                    check({vecs[v].name, "_do"}, cap_do, vecs[v].dout);
            end
            check({vecs[v].name, "_ntx"}, 32'(tx_q.size()), 32'(exp_ntx));
            if (exp_ntx > 0)
                check({vecs[v].name, "_tx"}, tx_word(), exp_tx);
            check({vecs[v].name, "_ptr"}, dbg_adr, vecs[v].ptr);
            check({vecs[v].name, "_cpu"}, 32'(cpu_n_reset), 32'(vecs[v].cpu));
        end

        // Write strobe lands the cycle after the last payload byte and lasts one clock.
        send_seq(48'h020F01020304, 6);
        check("wr_lat_strobe", 32'(dbg_mem_op), 32'h1);
        check("wr_lat_ready",  32'(rx_ready),   32'h0);
        @(posedge clk);
        #1;
        check("wr_one_clk",    32'(dbg_mem_op), 32'h0);
        check("wr_wren_clear", 32'(dbg_wren),   32'h0);
        drain();

        // Read: strobe, capture, then response.
        dbg_di = 32'h0;
        send(8'h03);
        check("rd_lat_strobe", 32'(dbg_mem_op), 32'h1);
        check("rd_lat_wren",   32'(dbg_wren),   32'h0);
        @(posedge clk);
        #1;
        check("rd_cap_no_op",  32'(dbg_mem_op), 32'h0);
        check("rd_cap_no_tx",  32'(tx_valid),   32'h0);
        @(posedge clk);
        #1;
        check("rd_tx_valid",   32'(tx_valid),   32'h1);
        drain();

        // Inter-byte timeout: a short gap is tolerated, a long one aborts.
        send_seq(48'h0100010000, 5);
        drain();
        begin
            int s0;
            s0 = strobes;
            send(8'h02);
            send(8'h0F);
            repeat (TO - 5) @(posedge clk);
            #1;
            send_seq(48'h11223344, 4);
            drain();
            check("to_short_gap_strobe", 32'(strobes - s0), 32'h1);
            check("to_short_gap_adr",    cap_adr,            32'h00000100);
            s0 = strobes;
            send_seq(48'h020F11, 3);
            repeat (TO + 5) @(posedge clk);
            #1;
            check("to_abort_no_strobe", 32'(strobes - s0), 32'h0);
            check("to_abort_ptr",       dbg_adr,           32'h00000104);
            tx_q.delete();
            dbg_di = 32'hCAFEF00D;
            send(8'h03);
            drain();
            check("to_read_strobe", 32'(strobes - s0), 32'h1);
            check("to_read_adr",    cap_adr,           32'h00000104);
            check("to_read_tx",     tx_word(),         32'hCAFEF00D);
        end

        // Response held under sink backpressure; no new bytes taken meanwhile.
        tx_q.delete();
        tx_ready = 1'b0;
        dbg_di   = 32'h44332211;
        send(8'h03);
        repeat (8) @(posedge clk);
        #1;
        check("bp_tx_valid", 32'(tx_valid), 32'h1);
        check("bp_tx_data",  32'(tx_data),  32'h11);
        check("bp_rx_ready", 32'(rx_ready), 32'h0);
        tx_ready = 1'b1;
        drain();
        check("bp_tx_word", tx_word(), 32'h44332211);

        // Reset in the middle of SETADR returns to the base pointer with no bus cycle.
        send(8'h01);
        send(8'h12);
        n_reset = 1'b0;
        #1;
        check("mid_rst_adr",   dbg_adr,          32'h00020000);
        check("mid_rst_ready", 32'(rx_ready),    32'h1);
        check("mid_rst_op",    32'(dbg_mem_op),  32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        dbg_di = 32'h0;
        send(8'h03);
        drain();
        check("post_rst_read_adr", cap_adr, 32'h00020000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks done", n_chk);
        $fatal(1, "global timeout");
    end
endmodule
